alu_pipe: RTL
=============

Name: alu_pipe

Overview:
- Parametrised, registered successor to the combinational execute-stage ALU.
- Accepts one operation per valid/ready handshake and returns a registered result plus a persistent [Z,C,N,V] flag register.
- Adds carry-in ops (ADC/SBC), ORR, ASR, ROR, and an iterative shift-add MUL.
- Sits between the decode/issue stage and writeback; back-pressure propagates through in_ready.

Parameters:
- WIDTH, 32, datapath width in bits (≥8).
- SHAMT_W, 8, number of low RHS bits used as the shift amount.

Ports:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  operation offered.
- in_ready  out  1  block can accept an operation this cycle.
- LHS  in  WIDTH  left operand.
- RHS  in  WIDTH  right operand / shift amount.
- uop  in  5  operation code.
- set_flags  in  1  when 1, the op updates the flag register.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- out_alu  out  WIDTH  registered result.
- flags  out  4  [0]=Z [1]=C [2]=N [3]=V, persistent register.

Behaviour:
- Reset (rst_n=0 at a clk edge): out_alu=0, flags=4'b0000, out_valid=0, state=IDLE, MUL counter=0. in_ready=0 during reset. Reset mid-MUL abandons the operation; no result is produced.
- Accept: accepted when in_valid && in_ready. in_ready = (state==IDLE) && (!out_valid || out_ready), so back-to-back single-cycle ops sustain 1 op/clk.
- Output hold: out_valid stays 1 and out_alu/flags are held until out_ready=1.
- FSM: IDLE, MUL, DONE.
  - IDLE→IDLE for single-cycle ops. Result is registered on the accept edge and out_valid=1 the next cycle (latency 1).
  - IDLE→MUL on MUL accept.
  - MUL runs WIDTH cycles, one shift-add step per cycle, then →DONE.
  - DONE asserts out_valid (latency WIDTH+1 from accept); DONE→IDLE when out_ready=1.
- uop encodings and results:
  - 00001 ADD: LHS+RHS.
  - 00010 SUB: LHS-RHS.
  - 00011 AND.
  - 00100 EOR.
  - 00101 CMP: LHS-RHS. The result is driven on out_alu, and the flags update even if set_flags=0.
  - 00110 LSL.
  - 00111 LSR.
  - 01000 MOV: RHS.
  - 01001 ADC: LHS+RHS+C.
  - 01010 SBC: LHS-RHS-!C.
  - 01011 ORR.
  - 01100 ASR.
  - 01101 ROR.
  - 01110 MUL: low WIDTH bits of LHS*RHS.
  - Any other uop: out_alu=0, flags unchanged, handshake completes normally.
- Flags (when updated):
  - Z = (result==0). N = result[WIDTH-1].
  - ADD/ADC: C = carry out of bit WIDTH-1. V = operands share a sign and the result sign differs.
  - SUB/CMP/SBC: C = NOT borrow (LHS≥RHS unsigned gives C=1 for SUB/CMP). V = operand signs differ and the result sign differs from LHS.
  - Shifts, with amt = RHS[SHAMT_W-1:0]:
    - amt=0: result=LHS, C unchanged.
    - LSL/LSR with 1≤amt≤WIDTH: C = last bit shifted out.
    - LSL/LSR with amt>WIDTH: result=0, C=0.
    - ASR with amt≥WIDTH: result = all copies of the sign bit, C = sign bit.
    - ROR uses amt mod WIDTH, with C = result[WIDTH-1] for nonzero amt. If amt mod WIDTH==0 and amt≠0, C = LHS[WIDTH-1].
  - Logic ops, MOV, MUL: C and V unchanged.
- Carry-in source: ADC/SBC read C from the flag register as it stands at the accept edge, so they see the flags of the immediately preceding op.

Decomposition:
- Shared package alu_pkg:
  - uop localparams (UOP_ADD … UOP_MUL).
  - Flag index constants FLAG_Z=0, FLAG_C=1, FLAG_N=2, FLAG_V=3.
  - FSM state encodings.
- Sub-module alu_shifter: combinational, parametrised by WIDTH/SHAMT_W. Takes LHS, amt, shift type and C_in; returns result and C_out.

Test Plan:
- WIDTH=32:
  - ADD 0xFFFFFFFF+0x1, set_flags=1 → out_alu=0x0, flags Z=1 C=1 N=0 V=0, out_valid one cycle after accept.
  - SUB 0x80000000-0x1 → out_alu=0x7FFFFFFF, C=1, V=1, N=0.
  - CMP 3,5 with set_flags=0 → flags N=1 C=0 Z=0.
- Carry chain: ADD 0xFFFFFFFF+0x1 (C=1), then ADC 0x0+0x0 → out_alu=0x1.
  - SBC 5,2 with C=0 → out_alu=0x2.
- Shifts:
  - LSL 0x80000001 by 1 → 0x00000002, C=1.
  - ASR 0x80000000 by 40 → 0xFFFFFFFF, C=1.
  - ROR 0x1 by 33 → 0x80000000.
  - LSR by 0 → LHS returned, C unchanged.
- MUL 0x10000*0x10001 → out_alu=0x00010000 after 33 cycles. in_ready=0 throughout; C/V preserved.
- Back-pressure: hold out_ready=0 for 3 cycles with in_valid=1 → in_ready=0, out_alu stable, no op lost.
  - Release out_ready → next op accepted the same cycle.
- Reset: assert rst_n=0 at MUL cycle 10 → next cycle out_valid=0, flags=0, in_ready=1 after rst_n returns to 1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants for the pipelined execute-stage ALU:
// micro-op encodings, flag bit positions and FSM / shifter encodings.
package alu_pkg;

   localparam logic [4:0] UOP_ADD = 5'b00001;
   localparam logic [4:0] UOP_SUB = 5'b00010;
   localparam logic [4:0] UOP_AND = 5'b00011;
   localparam logic [4:0] UOP_EOR = 5'b00100;
   localparam logic [4:0] UOP_CMP = 5'b00101;
   localparam logic [4:0] UOP_LSL = 5'b00110;
   localparam logic [4:0] UOP_LSR = 5'b00111;
   localparam logic [4:0] UOP_MOV = 5'b01000;
   localparam logic [4:0] UOP_ADC = 5'b01001;
   localparam logic [4:0] UOP_SBC = 5'b01010;
   localparam logic [4:0] UOP_ORR = 5'b01011;
   localparam logic [4:0] UOP_ASR = 5'b01100;
   localparam logic [4:0] UOP_ROR = 5'b01101;
   localparam logic [4:0] UOP_MUL = 5'b01110;

   localparam int FLAG_Z = 0;
   localparam int FLAG_C = 1;
   localparam int FLAG_N = 2;
   localparam int FLAG_V = 3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      SH_LSL = 2'd0,
      SH_LSR = 2'd1,
      SH_ASR = 2'd2,
      SH_ROR = 2'd3
   } shift_e;

endpackage

// File: rtl/alu_if.sv
// Issue-side and writeback-side valid/ready bundle of the ALU.
// master = producer/consumer around the ALU, slave = the ALU.
interface alu_if #(
   parameter int WIDTH = 32
) ();

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] LHS;
   logic [WIDTH-1:0] RHS;
   logic [4:0]       uop;
   logic             set_flags;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_alu;
   logic [3:0]       flags;

   modport master (
      output in_valid, LHS, RHS, uop, set_flags, out_ready,
      input  in_ready, out_valid, out_alu, flags
   );

   modport slave (
      input  in_valid, LHS, RHS, uop, set_flags, out_ready,
      output in_ready, out_valid, out_alu, flags
   );

endinterface

// File: rtl/alu_shifter.sv
// Combinational barrel shifter with carry-out for LSL/LSR/ASR/ROR.
// A zero shift amount passes LHS through and keeps the incoming carry.
module alu_shifter
   import alu_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 8
) (
   input  logic [WIDTH-1:0]   lhs_i,
   input  logic [SHAMT_W-1:0] amt_i,
   input  shift_e             type_i,
   input  logic               c_i,
   output logic [WIDTH-1:0]   res_o,
   output logic               c_o
);

   int unsigned      a;
   int unsigned      r;
   logic [WIDTH-1:0] t;

   // Select shift result and the last bit shifted out.
   always_comb begin
      a     = 32'(amt_i);
      r     = a % 32'(WIDTH);
      t     = '0;
      res_o = lhs_i;
      c_o   = c_i;
      if (a != 0) begin
         case (type_i)
            SH_LSL: begin
               if (a > 32'(WIDTH)) begin
                  res_o = '0;
                  c_o   = 1'b0;
               end else begin
                  res_o = lhs_i << a;
                  t     = lhs_i << (a - 1);
                  c_o   = t[WIDTH-1];
               end
            end
            SH_LSR: begin
               if (a > 32'(WIDTH)) begin
                  res_o = '0;
                  c_o   = 1'b0;
               end else begin
                  res_o = lhs_i >> a;
                  t     = lhs_i >> (a - 1);
                  c_o   = t[0];
               end
            end
            SH_ASR: begin
               if (a >= 32'(WIDTH)) begin
                  res_o = {WIDTH{lhs_i[WIDTH-1]}};
                  c_o   = lhs_i[WIDTH-1];
               end else begin
                  res_o = $unsigned($signed(lhs_i) >>> a);
                  t     = lhs_i >> (a - 1);
                  c_o   = t[0];
               end
            end
            SH_ROR: begin
               if (r == 0) begin
                  c_o = lhs_i[WIDTH-1];
               end else begin
                  res_o = (lhs_i >> r) | (lhs_i << (32'(WIDTH) - r));
                  c_o   = res_o[WIDTH-1];
               end
            end
            default: begin
               res_o = lhs_i;
               c_o   = c_i;
            end
         endcase
      end
   end

endmodule

// File: rtl/alu_pipe.sv
// Registered execute-stage ALU: one op per handshake, latency 1,
// iterative shift-add MUL, persistent [Z,C,N,V] flag register.
module alu_pipe
   import alu_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 8
) (
   input  logic  clk,
   input  logic  rst_n,
   alu_if.slave  bus
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   state_e           state_q;
   logic             out_valid_q;
   logic [WIDTH-1:0] out_alu_q;
   logic [3:0]       flags_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] acc_q;
   logic [WIDTH-1:0] mcand_q;
   logic [WIDTH-1:0] mplier_q;
   logic             mul_sf_q;

   logic             in_ready;
   logic             accept;
   logic [WIDTH-1:0] lhs;
   logic [WIDTH-1:0] rhs;
   logic [WIDTH-1:0] add_b;
   logic             add_cin;
   logic [WIDTH:0]   add_sum;
   logic             add_v;
   shift_e           sh_type;
   logic [WIDTH-1:0] sh_res;
   logic             sh_c;
   logic             is_arith;
   logic             is_logic;
   logic             is_shift;
   logic             upd;
   logic [WIDTH-1:0] res_d;
   logic [3:0]       flags_d;

   assign lhs = bus.LHS;
   assign rhs = bus.RHS;

   assign in_ready = rst_n && (state_q == ST_IDLE)
                     && (!out_valid_q || bus.out_ready);
   assign accept   = bus.in_valid && in_ready;

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.out_alu   = out_alu_q;
   assign bus.flags     = flags_q;

   assign is_arith = bus.uop inside
      {UOP_ADD, UOP_SUB, UOP_CMP, UOP_ADC, UOP_SBC};
   assign is_logic = bus.uop inside
      {UOP_AND, UOP_EOR, UOP_ORR, UOP_MOV};
   assign is_shift = bus.uop inside
      {UOP_LSL, UOP_LSR, UOP_ASR, UOP_ROR};

   // Shared adder: subtraction is LHS + ~RHS + carry-in.
   always_comb begin
      add_b   = rhs;
      add_cin = 1'b0;
      case (bus.uop)
         UOP_SUB, UOP_CMP: begin
            add_b   = ~rhs;
            add_cin = 1'b1;
         end
         UOP_ADC: add_cin = flags_q[FLAG_C];
         UOP_SBC: begin
            add_b   = ~rhs;
            add_cin = flags_q[FLAG_C];
         end
         default: begin
            add_b   = rhs;
            add_cin = 1'b0;
         end
      endcase
      add_sum = {1'b0, lhs} + {1'b0, add_b}
                + {{WIDTH{1'b0}}, add_cin};
      add_v   = (lhs[WIDTH-1] == add_b[WIDTH-1])
                && (add_sum[WIDTH-1] != lhs[WIDTH-1]);
   end

   // Map shift micro-ops onto the shifter's type encoding.
   always_comb begin
      case (bus.uop)
         UOP_LSR: sh_type = SH_LSR;
         UOP_ASR: sh_type = SH_ASR;
         UOP_ROR: sh_type = SH_ROR;
         default: sh_type = SH_LSL;
      endcase
   end

   alu_shifter #(
      .WIDTH   (WIDTH),
      .SHAMT_W (SHAMT_W)
   ) u_shifter (
      .lhs_i  (lhs),
      .amt_i  (rhs[SHAMT_W-1:0]),
      .type_i (sh_type),
      .c_i    (flags_q[FLAG_C]),
      .res_o  (sh_res),
      .c_o    (sh_c)
   );

   // Single-cycle result and next flag value for the offered op.
   always_comb begin
      res_d   = '0;
      flags_d = flags_q;
      upd     = 1'b0;
      unique case (1'b1)
         is_arith: begin
            res_d = add_sum[WIDTH-1:0];
            upd   = bus.set_flags || (bus.uop == UOP_CMP);
            if (upd) begin
               flags_d[FLAG_C] = add_sum[WIDTH];
               flags_d[FLAG_V] = add_v;
            end
         end
         is_logic: begin
            case (bus.uop)
               UOP_AND: res_d = lhs & rhs;
               UOP_EOR: res_d = lhs ^ rhs;
               UOP_ORR: res_d = lhs | rhs;
               default: res_d = rhs;
            endcase
            upd = bus.set_flags;
         end
         is_shift: begin
            res_d = sh_res;
            upd   = bus.set_flags;
            if (upd) begin
               flags_d[FLAG_C] = sh_c;
            end
         end
         default: begin
            res_d = '0;
            upd   = 1'b0;
         end
      endcase
      if (upd) begin
         flags_d[FLAG_Z] = (res_d == '0);
         flags_d[FLAG_N] = res_d[WIDTH-1];
      end
   end

   // Control FSM, MUL datapath and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         out_valid_q <= 1'b0;
         out_alu_q   <= '0;
         flags_q     <= '0;
         cnt_q       <= '0;
         acc_q       <= '0;
         mcand_q     <= '0;
         mplier_q    <= '0;
         mul_sf_q    <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  if (bus.uop == UOP_MUL) begin
                     state_q     <= ST_MUL;
                     out_valid_q <= 1'b0;
                     cnt_q       <= '0;
                     acc_q       <= '0;
                     mcand_q     <= lhs;
                     mplier_q    <= rhs;
                     mul_sf_q    <= bus.set_flags;
                  end else begin
                     out_valid_q <= 1'b1;
                     out_alu_q   <= res_d;
                     flags_q     <= flags_d;
                  end
               end else if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
               end
            end
            ST_MUL: begin
               if (mplier_q[0]) begin
                  acc_q <= acc_q + mcand_q;
               end
               mcand_q  <= mcand_q << 1;
               mplier_q <= mplier_q >> 1;
               cnt_q    <= cnt_q + 1'b1;
               if (cnt_q == CW'(WIDTH - 1)) begin
                  state_q <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (!out_valid_q) begin
                  out_valid_q <= 1'b1;
                  out_alu_q   <= acc_q;
                  if (mul_sf_q) begin
                     flags_q[FLAG_Z] <= (acc_q == '0);
                     flags_q[FLAG_N] <= acc_q[WIDTH-1];
                  end
               end else if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule
